// File: rtl/hashin_deser_pkg.sv
// Shared miner constants: frame geometry, expected header word and the
// deserializer state encoding. The upstream nonce generator imports the same
// package so both ends agree on the frame layout.
package hashin_deser_pkg;

  // Payload words per frame (640-bit block header / 64-bit FIFO words)
  localparam int MSG_WORDS = 10;
  localparam int MSG_BITS  = 640;

  // Frame header word: flag bit 63 plus the bit length 0x280
  localparam logic [63:0] HDR_WORD = 64'h8000_0000_0000_0280;

  // Deserializer states
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_DELIVER = 2'd2;
  localparam logic [1:0] ST_FLUSH   = 2'd3;

endpackage : hashin_deser_pkg

// File: rtl/hashin_deser.sv
// Hash-input deserializer: pops 64-bit words from a first-word-fall-through
// FIFO, checks for the frame header, shifts MSG_WORDS payload words into a
// block header register and hands it to the hash core with valid/ready.
// A stop request drains the FIFO and acknowledges once it runs dry.
module hashin_deser #(
  parameter int          MSG_WORDS = hashin_deser_pkg::MSG_WORDS,
  parameter logic [63:0] HDR_WORD  = hashin_deser_pkg::HDR_WORD
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [63:0]               hashin_fifo_dout,
  input  logic                      hashin_fifo_empty,
  output logic                      hashin_fifo_rd_en,
  input  logic                      stop,
  output logic                      stop_ack,
  output logic                      msg_valid,
  output logic [MSG_WORDS*64-1:0]   msg_data,
  input  logic                      msg_ready,
  output logic [31:0]               msg_cnt,
  output logic [15:0]               frame_err_cnt
);

  import hashin_deser_pkg::*;

  localparam int                 MSG_W    = MSG_WORDS * 64;
  localparam int                 CNT_W    = $clog2(MSG_WORDS + 1);
  localparam logic [CNT_W-1:0]   LAST_IDX = CNT_W'(MSG_WORDS - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] pay_cnt;
  logic             pop;

  // Read strobe: pop whenever data is present, except while holding a
  // message for the hash core or during reset.
  always_comb begin
    // NOTE: default first so every path assigns the output; no latch is inferred.
    hashin_fifo_rd_en = 1'b0;
    if (!rst && state != ST_DELIVER) begin
      hashin_fifo_rd_en = !hashin_fifo_empty;
    end
  end

  assign pop = hashin_fifo_rd_en && !hashin_fifo_empty;

  // Frame FSM, payload shift register and status counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: non-blocking assignments for all registered state so every
      // read in this block sees the pre-edge value.
      state         <= ST_IDLE;
      pay_cnt       <= '0;
      msg_data      <= '0;
      msg_valid     <= 1'b0;
      stop_ack      <= 1'b0;
      msg_cnt       <= '0;
      frame_err_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (stop) begin
            state <= ST_FLUSH;
          end else if (pop) begin
            if (hashin_fifo_dout == HDR_WORD) begin
              state   <= ST_COLLECT;
              pay_cnt <= '0;
            end else if (frame_err_cnt != 16'hFFFF) begin
              frame_err_cnt <= frame_err_cnt + 16'd1;
            end
          end
        end

        ST_COLLECT: begin
          if (stop) begin
            state <= ST_FLUSH;
          end else if (pop) begin
            msg_data <= {msg_data[MSG_W-65:0], hashin_fifo_dout};
            if (pay_cnt == LAST_IDX) begin
              state     <= ST_DELIVER;
              msg_valid <= 1'b1;
            end else begin
              pay_cnt <= pay_cnt + 1'b1;
            end
          end
        end

        ST_DELIVER: begin
          // A handshake in the same cycle as stop still counts as delivered
          if (msg_ready) begin
            msg_cnt   <= msg_cnt + 32'd1;
            msg_valid <= 1'b0;
          end
          if (stop) begin
            state     <= ST_FLUSH;
            msg_valid <= 1'b0;
          end else if (msg_ready) begin
            state <= ST_IDLE;
          end
        end

        default: begin // ST_FLUSH
          if (!stop) begin
            state    <= ST_IDLE;
            stop_ack <= 1'b0;
          end else if (hashin_fifo_empty) begin
            stop_ack <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule : hashin_deser

// File: tb/tb_hashin_deser.sv
// Directed bench for hashin_deser: a queue-backed FWFT FIFO model feeds the
// DUT, a posedge monitor counts pops and handshakes, and each scenario
// compares against hand-derived expected values.
module tb_hashin_deser;

  localparam logic [63:0] HDR = 64'h8000_0000_0000_0280;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [63:0]  hashin_fifo_dout = '0;
  logic         hashin_fifo_empty = 1'b1;
  logic         hashin_fifo_rd_en;
  logic         stop = 1'b0;
  logic         stop_ack;
  logic         msg_valid;
  logic [639:0] msg_data;
  logic         msg_ready = 1'b1;
  logic [31:0]  msg_cnt;
  logic [15:0]  frame_err_cnt;

  hashin_deser dut (
    .clk               (clk),
    .rst               (rst),
    .hashin_fifo_dout  (hashin_fifo_dout),
    .hashin_fifo_empty (hashin_fifo_empty),
    .hashin_fifo_rd_en (hashin_fifo_rd_en),
    .stop              (stop),
    .stop_ack          (stop_ack),
    .msg_valid         (msg_valid),
    .msg_data          (msg_data),
    .msg_ready         (msg_ready),
    .msg_cnt           (msg_cnt),
    .frame_err_cnt     (frame_err_cnt)
  );

  always #5 clk = ~clk;

  // FIFO model and monitor state
  logic [63:0]  q[$];
  logic         stall_mode  = 1'b0;
  logic         stall_phase = 1'b0;
  logic         stall_force = 1'b0;
  int           cyc = 0;
  int           pops = 0;
  int           rd_viol = 0;
  int           hs_cnt = 0;
  int           hs_cyc = 0;
  int           valid_cycles = 0;
  int           last_pop_cyc = 0;
  int           first_pop_cyc = 0;
  logic         mark = 1'b0;
  logic [639:0] hs_data = '0;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [639:0] got, input logic [639:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Expected block header for payload values first..first+9
  function automatic logic [639:0] exp_msg(input logic [63:0] first);
    logic [639:0] m = '0;
    for (int i = 0; i < 10; i++) m = {m[575:0], first + 64'(i)};
    return m;
  endfunction

  task automatic push_frame(input logic [63:0] first);
    q.push_back(HDR);
    for (int i = 0; i < 10; i++) q.push_back(first + 64'(i));
  endtask

  // Present the FIFO head away from the active edge
  always @(negedge clk) begin
    if (stall_mode) stall_phase = ~stall_phase;
    else            stall_phase = 1'b0;
    hashin_fifo_empty = (q.size() == 0) || stall_force || (stall_mode && stall_phase);
    hashin_fifo_dout  = (q.size() != 0) ? q[0] : 64'd0;
  end

  // Pop / handshake monitor on the active edge
  always @(posedge clk) begin
    cyc++;
    if (hashin_fifo_rd_en && hashin_fifo_empty) rd_viol++;
    if (!rst && hashin_fifo_rd_en && !hashin_fifo_empty) begin
      pops++;
      last_pop_cyc = cyc;
      if (mark) begin
        first_pop_cyc = cyc;
        mark = 1'b0;
      end
      void'(q.pop_front());
    end
    if (!rst && msg_valid) valid_cycles++;
    if (!rst && msg_valid && msg_ready) begin
      hs_cnt++;
      hs_cyc  = cyc;
      hs_data = msg_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_hs(input string tag, input int target);
    int budget = 200;
    while (hs_cnt < target && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check(tag, 640'(hs_cnt), 640'(target));
  endtask

  initial begin
    int p0, v0;
    logic         stable;
    logic [639:0] held;
    int           budget;

    // Reset: rd_en stays low even with data present
    q.push_back(64'hDEAD);
    tick(); tick();
    @(negedge clk);
    check("rst_rd_en",     640'(hashin_fifo_rd_en), 640'(0));
    check("rst_valid",     640'(msg_valid),         640'(0));
    check("rst_stop_ack",  640'(stop_ack),          640'(0));
    check("rst_msg_cnt",   640'(msg_cnt),           640'(0));
    check("rst_err_cnt",   640'(frame_err_cnt),     640'(0));
    check("rst_msg_data",  msg_data,                640'(0));
    tick();
    q.delete();
    rst = 1'b0;
    tick();

    // 1: basic frame, 12-cycle minimum frame time
    p0 = pops; mark = 1'b1;
    push_frame(64'd1);
    wait_hs("t1_hs", 1);
    check("t1_data",    hs_data,                        exp_msg(64'd1));
    check("t1_top",     640'(hs_data[639:576]),         640'(1));
    check("t1_bot",     640'(hs_data[63:0]),            640'(10));
    check("t1_pops",    640'(pops - p0),                640'(11));
    check("t1_lat",     640'(hs_cyc - last_pop_cyc),    640'(1));
    check("t1_frame",   640'(hs_cyc - first_pop_cyc),   640'(11));
    check("t1_vcyc",    640'(valid_cycles),             640'(1));
    tick();
    check("t1_msg_cnt", 640'(msg_cnt),                  640'(1));

    // 2: junk word then a good frame
    p0 = pops;
    q.push_back(64'h1234);
    push_frame(64'd11);
    wait_hs("t2_hs", 2);
    check("t2_data",    hs_data,              exp_msg(64'd11));
    check("t2_pops",    640'(pops - p0),      640'(12));
    tick();
    check("t2_err_cnt", 640'(frame_err_cnt),  640'(1));
    check("t2_msg_cnt", 640'(msg_cnt),        640'(2));

    // 3: empty toggling every other cycle
    p0 = pops;
    stall_mode = 1'b1;
    push_frame(64'd1);
    wait_hs("t3_hs", 3);
    stall_mode = 1'b0;
    check("t3_data",    hs_data,          exp_msg(64'd1));
    check("t3_pops",    640'(pops - p0),  640'(11));
    tick();
    check("t3_msg_cnt", 640'(msg_cnt),    640'(3));

    // 4: back-pressure from the hash core
    msg_ready = 1'b0;
    push_frame(64'd21);
    budget = 100;
    while (!msg_valid && budget > 0) begin @(negedge clk); budget--; end
    check("t4_valid_up", 640'(msg_valid), 640'(1));
    p0 = pops; v0 = hs_cnt; held = msg_data; stable = 1'b1;
    q.push_back(64'h5555);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!msg_valid || msg_data !== held || hashin_fifo_rd_en) stable = 1'b0;
    end
    check("t4_hold",     640'(stable),       640'(1));
    check("t4_no_pop",   640'(pops - p0),    640'(0));
    check("t4_no_hs",    640'(hs_cnt - v0),  640'(0));
    check("t4_held_msg", held,               exp_msg(64'd21));
    tick();
    msg_ready = 1'b1;
    wait_hs("t4_hs", 4);
    tick();
    check("t4_msg_cnt",  640'(msg_cnt),       640'(4));
    check("t4_err_cnt",  640'(frame_err_cnt), 640'(2)); // the 0x5555 word is junk

    // 5: stop after 4 payload words, 7 words queued behind
    p0 = pops;
    q.push_back(HDR);
    for (int i = 1; i <= 4; i++) q.push_back(64'(i));
    budget = 50;
    while ((pops - p0) < 5 && budget > 0) begin @(negedge clk); budget--; end
    check("t5_pre_pops", 640'(pops - p0), 640'(5));
    tick();
    stall_force = 1'b1;
    for (int i = 0; i < 7; i++) q.push_back(64'(100 + i));
    p0 = pops; v0 = valid_cycles;
    stop = 1'b1;
    stall_force = 1'b0;
    @(negedge clk); @(negedge clk);
    check("t5_ack_early", 640'(stop_ack), 640'(0));
    budget = 50;
    while (!stop_ack && budget > 0) begin @(negedge clk); budget--; end
    check("t5_ack",      640'(stop_ack),            640'(1));
    check("t5_pops",     640'(pops - p0),           640'(7));
    check("t5_no_valid", 640'(valid_cycles - v0),   640'(0));
    check("t5_msg_cnt",  640'(msg_cnt),             640'(4));
    check("t5_err_cnt",  640'(frame_err_cnt),       640'(2));
    tick();
    stop = 1'b0;
    tick();
    @(negedge clk);
    check("t5_ack_clr",  640'(stop_ack), 640'(0));
    push_frame(64'd31);
    wait_hs("t5_hs", 5);
    check("t5_data",     hs_data, exp_msg(64'd31));
    tick();
    check("t5_msg_cnt2", 640'(msg_cnt), 640'(5));

    // 6: stop coincident with a handshake
    msg_ready = 1'b0;
    push_frame(64'd41);
    budget = 100;
    while (!msg_valid && budget > 0) begin @(negedge clk); budget--; end
    check("t6_valid_up", 640'(msg_valid), 640'(1));
    tick();
    msg_ready = 1'b1;
    stop = 1'b1;
    budget = 50;
    while (!stop_ack && budget > 0) begin @(negedge clk); budget--; end
    check("t6_ack",     640'(stop_ack),  640'(1));
    check("t6_msg_cnt", 640'(msg_cnt),   640'(6));
    check("t6_data",    hs_data,         exp_msg(64'd41));
    check("t6_valid",   640'(msg_valid), 640'(0));
    tick();
    stop = 1'b0;
    tick(); tick();

    check("rd_en_while_empty", 640'(rd_viol), 640'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_hashin_deser
